// File: rtl/sar_search_pkg.sv
// Comparator relation codes and FSM encoding shared by the SAR search engine
// and the magnitude comparator it drives.
package sar_search_pkg;

  // Comparator code: relation of target to guess.
  localparam logic [1:0] CmpEq  = 2'b00;
  localparam logic [1:0] CmpGt  = 2'b01;
  localparam logic [1:0] CmpLt  = 2'b10;
  localparam logic [1:0] CmpBad = 2'b11;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StProbe  = 2'b01,
    StUpdate = 2'b10,
    StDone   = 2'b11
  } sar_state_e;

endpackage

// File: rtl/sar_search.sv
// Successive-approximation binary search over a 4-bit target, driving the probe
// operand of an external combinational magnitude comparator.
module sar_search
  import sar_search_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] cmp,
  output logic [3:0] guess,
  output logic       busy,
  output logic       done,
  output logic [3:0] result,
  output logic [2:0] steps,
  output logic       err
);

  sar_state_e state_q, state_d;
  logic [4:0] lo_q, lo_d;
  logic [4:0] hi_q, hi_d;
  logic [3:0] guess_q, guess_d;
  logic [3:0] result_q, result_d;
  logic [2:0] steps_q, steps_d;
  logic       err_q, err_d;
  logic [4:0] mid_sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      lo_q     <= 5'd0;
      hi_q     <= 5'd15;
      guess_q  <= 4'd0;
      result_q <= 4'd0;
      steps_q  <= 3'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      guess_q  <= guess_d;
      result_q <= result_d;
      steps_q  <= steps_d;
      err_q    <= err_d;
    end
  end

  // lo and hi never exceed 15 here, so the 5-bit sum cannot overflow.
  assign mid_sum = lo_q + hi_q;

  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    guess_d  = guess_q;
    result_d = result_q;
    steps_d  = steps_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          lo_d    = 5'd0;
          hi_d    = 5'd15;
          guess_d = 4'd7;
          steps_d = 3'd1;
          err_d   = 1'b0;
          state_d = StProbe;
        end
      end
      StProbe: begin
        unique case (cmp)
          CmpEq: begin
            result_d = guess_q;
            state_d  = StDone;
          end
          CmpGt: begin
            if (guess_q == 4'd15) begin
              err_d   = 1'b1;
              state_d = StDone;
            end else begin
              lo_d    = {1'b0, guess_q} + 5'd1;
              state_d = StUpdate;
            end
          end
          CmpLt: begin
            if (guess_q == 4'd0) begin
              err_d   = 1'b1;
              state_d = StDone;
            end else begin
              hi_d    = {1'b0, guess_q} - 5'd1;
              state_d = StUpdate;
            end
          end
          default: begin
            err_d   = 1'b1;
            state_d = StDone;
          end
        endcase
      end
      StUpdate: begin
        // An empty interval means the comparator answered inconsistently.
        if (lo_q > hi_q) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          guess_d = mid_sum[4:1];
          steps_d = steps_q + 3'd1;
          state_d = StProbe;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q == StProbe) || (state_q == StUpdate);
    done = (state_q == StDone);
  end

  assign guess  = guess_q;
  assign result = result_q;
  assign steps  = steps_q;
  assign err    = err_q;

endmodule

// File: tb/tb_sar_search.sv
// Directed bench for sar_search with a behavioural comparator model that can
// also emulate stuck or inconsistent comparators.
module tb_sar_search;
  import sar_search_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] cmp;
  logic [3:0] guess;
  logic       busy;
  logic       done;
  logic [3:0] result;
  logic [2:0] steps;
  logic       err;

  logic [3:0] target = 4'd0;
  int         mode = 0;  // 0 real, 1 stuck GT, 2 stuck BAD, 3 threshold at 8.5
  int         n_checks = 0;
  int         n_errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    cmp = CmpEq;
    case (mode)
      0: cmp = (target > guess) ? CmpGt : (target < guess) ? CmpLt : CmpEq;
      1: cmp = CmpGt;
      2: cmp = CmpBad;
      default: cmp = (guess <= 4'd8) ? CmpGt : CmpLt;
    endcase
  end

  sar_search dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .cmp    (cmp),
    .guess  (guess),
    .busy   (busy),
    .done   (done),
    .result (result),
    .steps  (steps),
    .err    (err)
  );

  task automatic check(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // g packs the expected guesses, first probe in g[3:0]. late means the search
  // ends from UPDATE rather than directly from the last PROBE.
  task automatic search(input string name, input int k, input logic [19:0] g,
                        input int exp_res, input int exp_err, input bit late,
                        input bit keep);
    start = 1'b1;
    tick();
    start = keep;
    for (int i = 0; i < k; i++) begin
      check({name, " guess"}, guess, g[4*i +: 4]);
      check({name, " busy"}, busy, 1);
      check({name, " done low"}, done, 0);
      tick();
      if (i < k - 1 || late) begin
        check({name, " upd done low"}, done, 0);
        tick();
      end
    end
    check({name, " done"}, done, 1);
    check({name, " busy low"}, busy, 0);
    check({name, " result"}, result, exp_res);
    check({name, " steps"}, steps, k);
    check({name, " err"}, err, exp_err);
  endtask

  initial begin
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst guess", guess, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst result", result, 0);
    check("rst steps", steps, 0);
    check("rst err", err, 0);
    tick();
    check("idle done", done, 0);

    mode = 0;
    target = 4'd7;
    search("t7", 1, 20'h00007, 7, 0, 1'b0, 1'b0);
    target = 4'd0;
    search("t0", 4, 20'h00137, 0, 0, 1'b0, 1'b0);
    tick();
    check("done held", done, 1);
    target = 4'd15;
    search("t15", 5, 20'hFEDB7, 15, 0, 1'b0, 1'b0);

    mode = 1;
    search("stuck_gt", 5, 20'hFEDB7, 15, 1, 1'b0, 1'b0);
    mode = 2;
    search("bad_code", 1, 20'h00007, 15, 1, 1'b0, 1'b0);
    mode = 3;
    search("lo_gt_hi", 4, 20'h089B7, 15, 1, 1'b1, 1'b0);

    // Reset during the second UPDATE.
    mode = 0;
    target = 4'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("mid guess 11", guess, 11);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst guess", guess, 0);
    check("mrst busy", busy, 0);
    check("mrst done", done, 0);
    check("mrst result", result, 0);
    check("mrst steps", steps, 0);
    check("mrst err", err, 0);
    search("t9", 3, 20'h009B7, 9, 0, 1'b0, 1'b0);

    // Back-to-back: start held high through PROBE/UPDATE and into DONE.
    target = 4'd5;
    search("b2b5", 3, 20'h00537, 5, 0, 1'b0, 1'b1);
    target = 4'd12;
    search("b2b12", 4, 20'h0CDB7, 12, 0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got stuck expected finish");
    $fatal(1, "timeout");
  end

endmodule
